// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, default width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_EQ  = 3'b000;  // A == B
    localparam logic [2:0] OP_SLT = 3'b001;  // signed A < B
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;  // not A, B ignored
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_ADD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels between a command source and the sequencer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_acc;
    logic             rsp_carry;
    logic             rsp_overflow;

    // Command source / response consumer side
    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_acc, rsp_carry, rsp_overflow
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_acc, rsp_carry, rsp_overflow
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-based initiator for a combinational ALU: takes commands, drives the ALU,
// waits ALU_LAT settle cycles, writes the result back and returns it with flags.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [2:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_carry,
    input  logic             i_alu_overflow,
    input  logic             i_flag_clr,
    output logic             o_sticky_c,
    output logic             o_sticky_v
);

    // Counter must hold ALU_LAT-1; keep at least one bit for ALU_LAT=1.
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_rsp_c;
    logic             r_rsp_v;
    logic             r_sticky_c;
    logic             r_sticky_v;
    logic             w_cmd_ready;
    logic             w_rsp_valid;
    logic             w_accept;
    logic             w_sample;

    assign w_accept = (r_state == IDLE) && bus.cmd_valid;
    assign w_sample = (r_state == EXEC) && (r_cnt == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_next_state = bus.cmd_load ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Command latch, settle countdown and result write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_cnt    <= '0;
            r_rsp_c  <= 1'b0;
            r_rsp_v  <= 1'b0;
        end else if (w_accept) begin
            if (bus.cmd_load) begin
                r_acc   <= bus.cmd_b;
                r_rsp_c <= 1'b0;
                r_rsp_v <= 1'b0;
            end else begin
                r_alu_a  <= r_acc;
                r_alu_b  <= bus.cmd_b;
                r_alu_op <= bus.cmd_op;
                r_cnt    <= CNT_W'(ALU_LAT - 1);
            end
        end else if (r_state == EXEC) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_acc   <= i_alu_result;
                r_rsp_c <= i_alu_carry;
                r_rsp_v <= i_alu_overflow;
            end
        end
    end

    // Sticky flags: a set on the sample edge beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_c <= 1'b0;
            r_sticky_v <= 1'b0;
        end else if (w_sample) begin
            r_sticky_c <= (r_sticky_c & ~i_flag_clr) | i_alu_carry;
            r_sticky_v <= (r_sticky_v & ~i_flag_clr) | i_alu_overflow;
        end else if (i_flag_clr) begin
            r_sticky_c <= 1'b0;
            r_sticky_v <= 1'b0;
        end
    end

    assign bus.cmd_ready    = w_cmd_ready;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.rsp_acc      = r_acc;
    assign bus.rsp_carry    = r_rsp_c;
    assign bus.rsp_overflow = r_rsp_v;
    assign o_alu_a          = r_alu_a;
    assign o_alu_b          = r_alu_b;
    assign o_alu_op         = r_alu_op;
    assign o_sticky_c       = r_sticky_c;
    assign o_sticky_v       = r_sticky_v;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (ALU_LAT=1 and 3), each with a 4-bit ALU model.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared command fields; cmd_valid is per instance
    logic       cmd_valid1 = 1'b0;
    logic       cmd_valid3 = 1'b0;
    logic       cmd_load   = 1'b0;
    logic [2:0] cmd_op     = 3'b000;
    logic [3:0] cmd_b      = 4'h0;
    logic       rsp_ready  = 1'b1;
    logic       flag_clr   = 1'b0;
    logic       sel3       = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    alu_cmd_sequencer_if #(.WIDTH(4)) bus1 ();
    alu_cmd_sequencer_if #(.WIDTH(4)) bus3 ();

    assign bus1.cmd_valid = cmd_valid1;
    assign bus1.cmd_load  = cmd_load;
    assign bus1.cmd_op    = cmd_op;
    assign bus1.cmd_b     = cmd_b;
    assign bus1.rsp_ready = rsp_ready;
    assign bus3.cmd_valid = cmd_valid3;
    assign bus3.cmd_load  = cmd_load;
    assign bus3.cmd_op    = cmd_op;
    assign bus3.cmd_b     = cmd_b;
    assign bus3.rsp_ready = rsp_ready;

    logic [3:0] a1, b1, r1, a3, b3, r3;
    logic [2:0] op1, op3;
    logic       c1, v1, c3, v3, sc1, sv1, sc3, sv3;

    // Reference 4-bit ALU: returns {carry, overflow, result}
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b111: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'b101: r = ~a;
            3'b100: r = a & b;
            3'b011: r = a | b;
            3'b010: r = a ^ b;
            3'b001: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {c, v, r};
    endfunction

    assign {c1, v1, r1} = alu_f(a1, b1, op1);
    assign {c3, v3, r3} = alu_f(a3, b3, op3);

    alu_cmd_sequencer #(.WIDTH(4), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .o_alu_a(a1), .o_alu_b(b1), .o_alu_op(op1),
        .i_alu_result(r1), .i_alu_carry(c1), .i_alu_overflow(v1),
        .i_flag_clr(flag_clr), .o_sticky_c(sc1), .o_sticky_v(sv1)
    );

    alu_cmd_sequencer #(.WIDTH(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .o_alu_a(a3), .o_alu_b(b3), .o_alu_op(op3),
        .i_alu_result(r3), .i_alu_carry(c3), .i_alu_overflow(v3),
        .i_flag_clr(flag_clr), .o_sticky_c(sc3), .o_sticky_v(sv3)
    );

    // Observation of whichever instance is under test
    logic       m_cmd_ready, m_rsp_valid, m_rsp_c, m_rsp_v, m_sc, m_sv;
    logic [3:0] m_acc;
    assign m_cmd_ready = sel3 ? bus3.cmd_ready    : bus1.cmd_ready;
    assign m_rsp_valid = sel3 ? bus3.rsp_valid    : bus1.rsp_valid;
    assign m_rsp_c     = sel3 ? bus3.rsp_carry    : bus1.rsp_carry;
    assign m_rsp_v     = sel3 ? bus3.rsp_overflow : bus1.rsp_overflow;
    assign m_acc       = sel3 ? bus3.rsp_acc      : bus1.rsp_acc;
    assign m_sc        = sel3 ? sc3 : sc1;
    assign m_sv        = sel3 ? sv3 : sv1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one command, wait for its response; lat counts clock edges
    // from (and including) the accepting edge up to the one that raises rsp_valid.
    task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [3:0] b, output int lat);
        @(negedge clk);
        cmd_load = ld;
        cmd_op   = op;
        cmd_b    = b;
        if (sel3) cmd_valid3 = 1'b1;
        else      cmd_valid1 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
        cmd_valid3 = 1'b0;
        lat = 1;
        while (!m_rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!m_rsp_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid, expected one within 20 cycles");
        end
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [3:0] b;
        logic [3:0] acc;
        logic       c;
        logic       v;
        logic       sc;
        logic       sv;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int lat;
        int hits;

        //          ld    op      b      acc    c     v     sc    sv
        tbl[0]  = '{1'b1, 3'b000, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'b111, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 3'b000, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 3'b110, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 3'b000, 4'hE, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 3'b001, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 3'b000, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 3'b000, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 3'b000, 4'hC, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'b100, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 3'b011, 4'h3, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 3'b010, 4'hF, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 3'b101, 4'hF, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 3'b110, 4'h4, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 3'b000, 4'h7, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 3'b001, 4'h8, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 3'b001, 4'h7, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state, observed while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst cmd_ready", 8'(bus1.cmd_ready), 8'h1);
        chk("rst rsp_valid", 8'(bus1.rsp_valid), 8'h0);
        chk("rst rsp_acc",   8'(bus1.rsp_acc),   8'h0);
        chk("rst alu_a",     8'(a1),             8'h0);
        chk("rst sticky",    8'({sc1, sv1}),     8'h0);
        chk("rst acc3",      8'(bus3.rsp_acc),   8'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table of commands on the ALU_LAT=1 instance
        for (int i = 0; i < 17; i++) begin
            do_cmd(tbl[i].ld, tbl[i].op, tbl[i].b, lat);
            chk($sformatf("row%0d latency", i), 8'(lat), tbl[i].ld ? 8'd1 : 8'd2);
            chk($sformatf("row%0d acc", i),     8'(m_acc),   8'(tbl[i].acc));
            chk($sformatf("row%0d carry", i),   8'(m_rsp_c), 8'(tbl[i].c));
            chk($sformatf("row%0d ovf", i),     8'(m_rsp_v), 8'(tbl[i].v));
            chk($sformatf("row%0d sticky", i),  8'({m_sc, m_sv}), 8'({tbl[i].sc, tbl[i].sv}));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d back idle", i), 8'({m_cmd_ready, m_rsp_valid}), 8'h2);
        end

        // Clear in IDLE
        @(negedge clk);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("clr idle sticky", 8'({m_sc, m_sv}), 8'h0);

        // Back-pressure: 1111 + 0001 held in RESP for 5 cycles
        do_cmd(1'b1, 3'b000, 4'hF, lat);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        do_cmd(1'b0, 3'b111, 4'h1, lat);
        chk("bp latency", 8'(lat), 8'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d rsp", k), 8'({m_rsp_valid, m_acc, m_rsp_c, m_rsp_v}), 8'b1_0000_1_0);
            chk($sformatf("bp%0d cmd_ready", k), 8'(m_cmd_ready), 8'h0);
        end
        chk("bp sticky", 8'({m_sc, m_sv}), 8'h2);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hits = 0;
        for (int k = 0; k < 4; k++) begin
            if (m_rsp_valid) hits++;
            @(posedge clk);
            #1;
        end
        chk("bp single response", 8'(hits), 8'd0);

        // Clear coinciding with a carry sample: set wins
        do_cmd(1'b1, 3'b000, 4'hF, lat);
        @(posedge clk);
        #1;
        @(negedge clk);
        cmd_load = 1'b0; cmd_op = 3'b111; cmd_b = 4'h1; cmd_valid1 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
        @(negedge clk);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("clr+set rsp", 8'({m_rsp_valid, m_acc, m_rsp_c}), 8'b1_0000_1);
        chk("clr+set sticky_c", 8'(m_sc), 8'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("clr after set", 8'(m_sc), 8'h0);

        // ALU_LAT=3 instance: latency, then reset during EXEC
        sel3 = 1'b1;
        do_cmd(1'b1, 3'b000, 4'h2, lat);
        chk("lat3 load latency", 8'(lat), 8'd1);
        @(posedge clk);
        #1;
        do_cmd(1'b0, 3'b111, 4'h3, lat);
        chk("lat3 add latency", 8'(lat), 8'd4);
        chk("lat3 add acc", 8'(m_acc), 8'h5);
        @(posedge clk);
        #1;
        @(negedge clk);
        cmd_load = 1'b0; cmd_op = 3'b111; cmd_b = 4'h1; cmd_valid3 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid3 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst outputs", 8'({m_rsp_valid, m_cmd_ready, m_acc}), 8'b0_1_0000);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (m_rsp_valid) hits++;
        end
        chk("midrst no response", 8'(hits), 8'd0);
        do_cmd(1'b0, 3'b111, 4'h4, lat);
        chk("post-rst latency", 8'(lat), 8'd4);
        chk("post-rst rsp", 8'({m_acc, m_rsp_c, m_rsp_v}), 8'b0100_0_0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
